// File: rtl/acc_pkg.sv
// Shared opcode/state types and opcode classification for the accumulator slice.
// ACC_ROTATE_EN enables opcode 7 (ROL); otherwise it behaves as a NOP.
package acc_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_ROL  = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ops that walk one bit per clock and may take several cycles.
  function automatic logic is_shift_op(input op_e o);
`ifdef ACC_ROTATE_EN
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL);
`else
    return (o == OP_SHL) || (o == OP_SHR);
`endif
  endfunction

  function automatic logic is_single_op(input op_e o);
    return (o == OP_LOAD) || (o == OP_CLR) || (o == OP_INC) || (o == OP_DEC);
  endfunction

endpackage

// File: rtl/acc_step.sv
// Combinational single-step next accumulator value and carry for one opcode.
// Shift/rotate ops move exactly one bit position; ROL exists only with ACC_ROTATE_EN.
module acc_step
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_W
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             carry_o
);

  always_comb begin
    acc_o   = acc_i;
    carry_o = carry_i;
    case (op_i)
      OP_LOAD: begin
        acc_o   = load_i;
        carry_o = 1'b0;
      end
      OP_CLR: begin
        acc_o   = '0;
        carry_o = 1'b0;
      end
      OP_INC: begin
        acc_o   = acc_i + WIDTH'(1);
        carry_o = (acc_i == '1);
      end
      OP_DEC: begin
        acc_o   = acc_i - WIDTH'(1);
        carry_o = (acc_i == '0);
      end
      OP_SHL: begin
        acc_o   = {acc_i[WIDTH-2:0], 1'b0};
        carry_o = acc_i[WIDTH-1];
      end
      OP_SHR: begin
        acc_o   = {1'b0, acc_i[WIDTH-1:1]};
        carry_o = acc_i[0];
      end
`ifdef ACC_ROTATE_EN
      OP_ROL: begin
        acc_o   = {acc_i[WIDTH-2:0], acc_i[WIDTH-1]};
        carry_o = acc_i[WIDTH-1];
      end
`endif
      default: begin
        acc_o   = acc_i;
        carry_o = carry_i;
      end
    endcase
  end

endmodule

// File: rtl/acc_shift_unit.sv
// Accumulator with load/clear/inc/dec and multi-cycle shift (one bit per clock).
// Define ACC_ROTATE_EN to enable opcode 7 (ROL); otherwise opcode 7 is a silent NOP.
module acc_shift_unit
  import acc_pkg::*;
#(
  parameter int WIDTH   = ACC_W,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   acc_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               op_ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   acc_out,
  output logic               carry,
  output logic               zero
);

  state_e             state_q;
  op_e                op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic               carry_q;
  logic               zero_q;
  logic               done_q;

  op_e                op_in;
  op_e                step_op;
  logic [WIDTH-1:0]   acc_d;
  logic               carry_d;

  assign op_in = op_e'(op);

  // While shifting, the engine replays the latched op; otherwise it previews the incoming op.
  always_comb begin
    step_op = op_in;
    if (state_q == ST_SHIFT) begin
      step_op = op_q;
    end
  end

  acc_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_i   (step_op),
    .acc_i  (acc_q),
    .carry_i(carry_q),
    .load_i (acc_in),
    .acc_o  (acc_d),
    .carry_o(carry_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            if (is_shift_op(op_in)) begin
              if (shamt == '0) begin
                done_q <= 1'b1;
              end else begin
                acc_q   <= acc_d;
                carry_q <= carry_d;
                zero_q  <= (acc_d == '0);
                if (shamt > SHAMT_W'(1)) begin
                  state_q <= ST_SHIFT;
                  op_q    <= op_in;
                  cnt_q   <= shamt - SHAMT_W'(1);
                end else begin
                  done_q <= 1'b1;
                end
              end
            end else if (is_single_op(op_in)) begin
              acc_q   <= acc_d;
              carry_q <= carry_d;
              zero_q  <= (acc_d == '0);
              done_q  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          zero_q  <= (acc_d == '0);
          cnt_q   <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign op_ready = ~busy;
  assign done     = done_q;
  assign acc_out  = acc_q;
  assign carry    = carry_q;
  assign zero     = zero_q;

endmodule

// File: doc/acc_shift_unit.md
# acc_shift_unit

Parametrised accumulator for the 8-bit processor datapath, replacing plain load/hold registers. It adds opcode-driven in-place operations: load, clear, increment, decrement, and multi-cycle shift/rotate by N. It also keeps registered carry and zero flags. It sits between the ALU result bus and the operand/flag consumers, and accepts one operation at a time through a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, accumulator width in bits (≥2)
- SHAMT_W, 3, width of shift-amount input; legal shift counts 0..WIDTH-1

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op_valid  input  1  operation request
- op  input  3  opcode (see Operation)
- acc_in  input  WIDTH  load data
- shamt  input  SHAMT_W  shift/rotate count
- op_ready  output  1  unit can accept an op; equals !busy
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse, op completed
- acc_out  output  WIDTH  accumulator register
- carry  output  1  registered carry/borrow/shifted-out bit
- zero  output  1  registered, high when acc_out == 0

## Operation
- Handshake: an op is accepted at a rising edge with op_valid && op_ready. op_valid while busy is ignored, not queued.
- Opcodes and their effect on the accumulator and carry:
  - 0 NOP: holds all state; no done.
  - 1 LOAD: acc ← acc_in; carry ← 0.
  - 2 CLR: acc ← 0; carry ← 0.
  - 3 INC: acc ← acc+1 mod 2^WIDTH; carry ← 1 on wrap from all-ones, else 0.
  - 4 DEC: acc ← acc−1 mod 2^WIDTH; carry ← 1 on borrow from 0, else 0.
  - 5 SHL: logical left shift by shamt; zeros shift in.
  - 6 SHR: logical right shift by shamt; zeros shift in.
  - 7 ROL: rotate left by shamt; only when ACC_ROTATE_EN is defined.
- Shift/rotate carry: the last bit shifted out; rotate copies the wrapped bit.
- Shift/rotate with shamt=0: single-cycle; acc and carry unchanged; done pulses.
- zero: always tracks the registered acc.
- FSM:
  - IDLE → SHIFT on accepting a shift/rotate with shamt ≥ 2.
  - SHIFT → IDLE when the remaining count reaches 0.
  - Shift/rotate with shamt = 1 stays in IDLE.
- Shift engine: one bit position per clock. The first step is performed at the accepting edge; the counter is loaded with shamt−1 and decrements each SHIFT edge.

## Timing
- Reset values (asynchronous, immediate): acc_out=0, carry=0, zero=1, busy=0, op_ready=1, done=0, FSM=IDLE, counter=0.
- Single-cycle ops (LOAD/CLR/INC/DEC, shift with shamt ≤ 1):
  - Result visible after the accepting edge E0.
  - done=1 for the cycle after E0.
  - op_ready stays 1, so back-to-back ops are accepted every cycle.
- Shift with shamt=k ≥ 2:
  - Steps occur at edges E0..E(k−1).
  - busy=1 from after E0 until after E(k−1).
  - done=1 for the cycle after E(k−1).
  - The next op can be accepted at E(k).
- Reset mid-shift: the shift is aborted, no done is produced, and the unit is ready in the cycle after reset deasserts.
- acc_in and shamt are sampled only at the accepting edge; changes during SHIFT have no effect.

## Configuration
- ACC_ROTATE_EN defined: opcode 7 performs ROL as specified, including multi-cycle behaviour.
- ACC_ROTATE_EN undefined: opcode 7 is accepted as NOP. State is unchanged, there is no done pulse, and no rotate logic is synthesised.

## Structure
- Shared package acc_pkg:
  - opcode enum: OP_NOP, OP_LOAD, OP_CLR, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_ROL
  - FSM state enum: ST_IDLE, ST_SHIFT
  - default ACC_W = 8
- Sub-module acc_step: combinational single-step next-value and carry for a given op. Instantiated once; used both at acceptance and during SHIFT.

## Test plan
- Reset asserted → acc_out=0x00, zero=1, carry=0, op_ready=1, done=0.
- LOAD 0xFF, then INC → acc=0x00, carry=1, zero=1, done pulse after each op.
- CLR, then DEC → acc=0xFF, carry=1, zero=0.
- LOAD 0x81, then SHL shamt=3:
  - busy high 2 cycles, op_ready low, an INC issued while busy is ignored.
  - acc=0x08, carry=0, a single done after the 3rd edge.
- LOAD 0x81, then op 7 with shamt=1:
  - with ACC_ROTATE_EN: acc=0x03, carry=1, done pulse.
  - without ACC_ROTATE_EN: acc=0x81, no done.
- SHR 0xF0 by shamt=4, with reset asserted after the 2nd step → acc=0x00 immediately, busy=0, no done; a LOAD accepted after reset release.
